des_key_schedule: RTL and testbench
===================================

# des_key_schedule

Iterative DES key-schedule generator. It takes a 64-bit DES key, applies PC-1, and presents the sixteen 48-bit round subkeys one at a time on `subkey_o`, in encrypt order (K1..K16) or decrypt order (K16..K1). Each subkey comes from a per-round rotation of the C/D halves followed by PC-2. It sits beside the round datapath, and `subkey_o` is XORed with the 48-bit expansion-permutation output of each round.

## Interface
Parameters:
- none. All widths are fixed by FIPS 46-3.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_n_i`  in  1  synchronous, active-low reset.
- `key_i`  in  [1:64]  DES key, bit 1 = MSB. Parity bits 8,16,…,64 are ignored.
- `decrypt_i`  in  1  0 = encrypt order K1..K16, 1 = decrypt order K16..K1. Sampled with `start_i`.
- `start_i`  in  1  load `key_i` and begin a schedule. Honoured only in IDLE.
- `next_i`  in  1  the consumer has taken the current subkey; advance. Honoured only while `valid_o` = 1.
- `subkey_o`  out  [1:48]  current round subkey = PC-2(C,D). Forced to 0 when `valid_o` = 0.
- `round_o`  out  [4:0]  index n of the subkey presented (1..16). 0 when not valid.
- `valid_o`  out  1  `subkey_o` holds a valid subkey.
- `busy_o`  out  1  high in ACTIVE; equal to `valid_o`.
- `done_o`  out  1  one-cycle pulse after the 16th subkey is consumed.

## Operation
- Registers:
  - C[1:28], D[1:28]
  - dir flag
  - round counter, 5 bits
  - state: IDLE or ACTIVE
  - done flag
- PC-1 maps `key_i` to C0 (left 28) and D0 (right 28). PC-2 maps {C,D} (56 bits) to 48 bits. Both are pure wiring per FIPS 46-3.
- Shift schedule, rounds 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (total 28).
- IDLE + `start_i`:
  - Encrypt: C,D ← rotl(C0,1), rotl(D0,1); round ← 1.
  - Decrypt: C,D ← C0, D0 (which equals C16,D16); round ← 16.
  - Either way, dir ← `decrypt_i` and state → ACTIVE.
- ACTIVE + `next_i`, not last:
  - Encrypt: C,D ← rotl by shift[round+1]; round ← round+1.
  - Decrypt: C,D ← rotr by shift[round]; round ← round−1.
- ACTIVE + `next_i` on the last subkey (round 16 in encrypt, round 1 in decrypt): state → IDLE, and `done_o` = 1 for the following cycle only.
- ACTIVE without `next_i`: all outputs hold. The consumer may stall indefinitely.
- `start_i` in ACTIVE is ignored; the current schedule continues.
- `next_i` in IDLE is ignored.
- `start_i` and `next_i` together in IDLE: start wins, and `next_i` is not applied to the newly loaded key.
- `decrypt_i` is don't-care except in the `start_i` cycle.
- `start_i` in the same cycle `done_o` is high (state is IDLE) is accepted normally.

## Timing
- Reset (`rst_n_i` = 0 at an edge), from any state, including mid-schedule:
  - state ← IDLE; C, D, round and dir cleared.
  - The next cycle shows `valid_o` = 0, `busy_o` = 0, `done_o` = 0, `subkey_o` = 0, `round_o` = 0.
  - Reset has priority over `start_i` and `next_i`.
- Start latency: `start_i` sampled at edge t. From t+1, `valid_o` = 1 with K1 (encrypt) or K16 (decrypt).
- Throughput: one subkey per cycle while `next_i` is held high. With `next_i` high continuously from the first valid cycle:
  - A full schedule takes 16 valid cycles.
  - `done_o` is asserted in cycle 17 with `valid_o` = 0.
- `subkey_o` and `round_o` are combinational from registers only, with no combinational path from any input. They are stable for the whole valid cycle.
- Rotation is modulo 28 within each half. C and D never exchange bits.

## Test plan
- Key 0x133457799BBCDFF1, encrypt, `next_i` held high:
  - K1 = 0x1B02EFFC7072, K2 = 0x79AED9DBC9E5, K16 = 0xCB3D8B0E17F5.
  - `round_o` steps 1..16; `done_o` is a single pulse in cycle 17.
- Same key, decrypt:
  - First subkey is 0xCB3D8B0E17F5 with `round_o` = 16; last is 0x1B02EFFC7072 with `round_o` = 1.
  - The full sequence equals the encrypt sequence reversed.
- Key 0x0101010101010101 (parity bits only): all 16 subkeys = 0. Confirms parity bits are ignored.
- Stall and priority:
  - Hold `next_i` low for 5 cycles at K2: `subkey_o` stays 0x79AED9DBC9E5 and `round_o` stays 2.
  - Pulse `start_i` with a different key mid-schedule: ignored, and the sequence continues to K3.
- Reset mid-schedule at round 7: the next cycle has all outputs 0. A subsequent `start_i` yields K1 after one cycle.
- `start_i` and `next_i` asserted together in IDLE: `round_o` = 1 after the edge, not 2.
- Back-to-back: `start_i` asserted in the `done_o` cycle begins a new schedule, with `valid_o` high the following cycle.

Source files
------------

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: loads a key through PC-1, then steps the C/D halves
// one round per consumer handshake and presents PC-2(C,D) as the current subkey.
module des_key_schedule (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [1:64] key_i,
    input  logic        decrypt_i,
    input  logic        start_i,
    input  logic        next_i,
    output logic [1:48] subkey_o,
    output logic [4:0]  round_o,
    output logic        valid_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [1:56] pc1(input logic [1:64] k);
        logic [1:56] r;
        for (int i = 0; i < 56; i++) r[i+1] = k[PC1[i]];
        return r;
    endfunction

    function automatic logic [1:48] pc2(input logic [1:28] c, input logic [1:28] d);
        logic [1:56] cd;
        logic [1:48] r;
        cd = {c, d};
        for (int i = 0; i < 48; i++) r[i+1] = cd[PC2[i]];
        return r;
    endfunction

    // Rounds 1, 2, 9 and 16 rotate by one position; every other round by two.
    function automatic logic double_shift(input logic [4:0] n);
        return !(n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16);
    endfunction

    function automatic logic [1:28] rotl(input logic [1:28] x, input logic two);
        return two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
    endfunction

    function automatic logic [1:28] rotr(input logic [1:28] x, input logic two);
        return two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
    endfunction

    state_t      state, state_next;
    logic [1:28] c, c_next, d, d_next;
    logic [4:0]  round, round_next;
    logic        dir, dir_next;
    logic        done, done_next;
    logic [1:56] key_pc1;
    logic        last;
    logic        unused_parity;

    assign key_pc1       = pc1(key_i);
    assign unused_parity = ^{key_i[8], key_i[16], key_i[24], key_i[32],
                             key_i[40], key_i[48], key_i[56], key_i[64]};
    assign last          = dir ? (round == 5'd1) : (round == 5'd16);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            c     <= '0;
            d     <= '0;
            round <= '0;
            dir   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            c     <= c_next;
            d     <= d_next;
            round <= round_next;
            dir   <= dir_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        c_next     = c;
        d_next     = d;
        round_next = round;
        dir_next   = dir;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = ACTIVE;
                    dir_next   = decrypt_i;
                    // Total rotation over 16 rounds is 28, so C0/D0 already equal C16/D16.
                    if (decrypt_i) begin
                        c_next     = key_pc1[1:28];
                        d_next     = key_pc1[29:56];
                        round_next = 5'd16;
                    end else begin
                        c_next     = rotl(key_pc1[1:28], 1'b0);
                        d_next     = rotl(key_pc1[29:56], 1'b0);
                        round_next = 5'd1;
                    end
                end
            end
            ACTIVE: begin
                if (next_i) begin
                    if (last) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else if (dir) begin
                        c_next     = rotr(c, double_shift(round));
                        d_next     = rotr(d, double_shift(round));
                        round_next = round - 5'd1;
                    end else begin
                        c_next     = rotl(c, double_shift(round + 5'd1));
                        d_next     = rotl(d, double_shift(round + 5'd1));
                        round_next = round + 5'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign valid_o  = (state == ACTIVE);
    assign busy_o   = valid_o;
    assign done_o   = done;
    assign subkey_o = valid_o ? pc2(c, d) : '0;
    assign round_o  = valid_o ? round : 5'd0;

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: stimulus queues expected subkeys, a
// negedge monitor compares whatever the DUT presents.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst_n, decrypt, start, next;
    logic [63:0] key;
    logic [47:0] subkey;
    logic [4:0]  rnd;
    logic        valid, busy, done;

    always #5 clk = ~clk;

    des_key_schedule dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .key_i     (key),
        .decrypt_i (decrypt),
        .start_i   (start),
        .next_i    (next),
        .subkey_o  (subkey),
        .round_o   (rnd),
        .valid_o   (valid),
        .busy_o    (busy),
        .done_o    (done)
    );

    localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_PAR = 64'h0101010101010101;

    // Subkeys K1..K16 for KEY_A.
    localparam logic [47:0] KE [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    typedef struct packed {
        logic [47:0] sk;
        logic [4:0]  n;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_enc(input bit zero);
        exp_t e;
        for (int i = 1; i <= 16; i++) begin
            e.sk   = zero ? 48'h0 : KE[i-1];
            e.n    = 5'(i);
            e.last = (i == 16);
            sb.push_back(e);
        end
    endtask

    task automatic push_dec();
        exp_t e;
        for (int i = 16; i >= 1; i--) begin
            e.sk   = KE[i-1];
            e.n    = 5'(i);
            e.last = (i == 1);
            sb.push_back(e);
        end
    endtask

    // Monitor: compare the presented subkey against the queue head; pop on handshake.
    initial begin
        exp_t e;
        logic done_due;
        done_due = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("done", done, done_due);
                done_due = 1'b0;
                chk("busy_eq_valid", busy, valid);
                if (valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_valid actual=%h required=no_output", subkey);
                    end else begin
                        e = sb[0];
                        chk("subkey", subkey, e.sk);
                        chk("round", rnd, e.n);
                        if (next) begin
                            void'(sb.pop_front());
                            done_due = e.last;
                        end
                    end
                end else begin
                    chk("idle_subkey", subkey, 48'h0);
                    chk("idle_round", rnd, 5'd0);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; next = 1'b0; decrypt = 1'b0; key = '0;
        tick();
        tick();
        chk("reset_valid", valid, 1'b0);
        chk("reset_subkey", subkey, 48'h0);
        chk("reset_done", done, 1'b0);
        mon_en = 1'b1;
        rst_n  = 1'b1;

        // Encrypt, next held high
        push_enc(1'b0);
        key = KEY_A; start = 1'b1; tick();
        start = 1'b0; next = 1'b1;
        repeat (16) tick();

        // Back-to-back decrypt started in the done cycle
        push_dec();
        start = 1'b1; decrypt = 1'b1; next = 1'b0; tick();
        start = 1'b0; decrypt = 1'b0; next = 1'b1;
        repeat (16) tick();
        next = 1'b0; tick();

        // Parity-only key gives all-zero subkeys
        push_enc(1'b1);
        key = KEY_PAR; start = 1'b1; tick();
        start = 1'b0; next = 1'b1;
        repeat (16) tick();
        next = 1'b0; tick();

        // Stall at K2, then an ignored start with another key
        push_enc(1'b0);
        key = KEY_A; start = 1'b1; tick();
        start = 1'b0; next = 1'b1; tick();
        next = 1'b0;
        repeat (5) tick();
        next = 1'b1; start = 1'b1; key = 64'hFFFF_FFFF_FFFF_FFFF; tick();
        start = 1'b0; key = KEY_A;
        repeat (14) tick();
        next = 1'b0; tick();

        // Reset while K7 is presented
        push_enc(1'b0);
        start = 1'b1; tick();
        start = 1'b0; next = 1'b1;
        repeat (6) tick();
        next = 1'b0; rst_n = 1'b0; tick();
        sb.delete();
        chk("midreset_valid", valid, 1'b0);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_subkey", subkey, 48'h0);
        chk("midreset_round", rnd, 5'd0);
        chk("midreset_done", done, 1'b0);
        rst_n = 1'b1;
        push_enc(1'b0);
        start = 1'b1; tick();
        start = 1'b0; next = 1'b1;
        repeat (16) tick();
        next = 1'b0; tick();

        // start and next together in IDLE: start wins
        push_enc(1'b0);
        start = 1'b1; next = 1'b1; tick();
        start = 1'b0;
        chk("start_next_round", rnd, 5'd1);
        repeat (16) tick();
        next = 1'b0; tick();

        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        chk("queue_drained", sb.size(), 0);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
